// File: rtl/arrow_pool_ctrl_pkg.sv
// arrow_pkg: state encoding, {x,y} packing offsets and defaults shared by the arrow pool
package arrow_pkg;
    localparam int POS_W = 10;
    localparam int X_LSB = POS_W;
    localparam int Y_LSB = 0;
    localparam int SLOT_W = 2 * POS_W;
    localparam int DEF_ARROW_SPEED = 5;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_MOVE  = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;
    localparam logic [1:0] ST_SPAWN = 2'd3;
endpackage

// File: rtl/arrow_pool_ctrl_if.sv
// arrow_pool_ctrl_if: player/target inputs and arrow pool outputs of the projectile scheduler
interface arrow_pool_ctrl_if import arrow_pkg::*; #(parameter int NUM_ARROWS = 4);
    logic                       frame_tick;
    logic                       fire_button;
    logic [SLOT_W-1:0]          playerPos;
    logic [POS_W-1:0]           block_x, block_y, block_w, block_h;
    logic [POS_W-1:0]           lizard_x, lizard_y, lizard_w, lizard_h;
    logic [NUM_ARROWS-1:0]      arrow_valid;
    logic [SLOT_W*NUM_ARROWS-1:0] arrow_pos;
    logic                       block_defeated;
    logic                       lizard_defeated;
    logic                       fire_ack;
    logic                       busy;
    modport master (
        output frame_tick, fire_button, playerPos,
        output block_x, block_y, block_w, block_h,
        output lizard_x, lizard_y, lizard_w, lizard_h,
        input  arrow_valid, arrow_pos, block_defeated, lizard_defeated, fire_ack, busy
    );
    modport slave (
        input  frame_tick, fire_button, playerPos,
        input  block_x, block_y, block_w, block_h,
        input  lizard_x, lizard_y, lizard_w, lizard_h,
        output arrow_valid, arrow_pos, block_defeated, lizard_defeated, fire_ack, busy
    );
endinterface

// File: rtl/arrow_pool_ctrl_aabb_hit.sv
// aabb_hit: inclusive point-in-box test; box edges summed at 11 bits so they never wrap
module aabb_hit import arrow_pkg::*; (
    input  logic [POS_W-1:0] px,
    input  logic [POS_W-1:0] py,
    input  logic [POS_W-1:0] bx,
    input  logic [POS_W-1:0] by,
    input  logic [POS_W-1:0] bw,
    input  logic [POS_W-1:0] bh,
    output logic             hit
);
    logic [POS_W:0] x_hi, y_hi;
    assign x_hi = {1'b0, bx} + {1'b0, bw};
    assign y_hi = {1'b0, by} + {1'b0, bh};
    assign hit  = (px >= bx) && ({1'b0, px} <= x_hi) && (py >= by) && ({1'b0, py} <= y_hi);
endmodule

// File: rtl/arrow_pool_ctrl.sv
// arrow_pool_ctrl: per-frame move/collide/spawn scheduler for the arrow pool; ARROW_COOLDOWN_EN builds the spawn cooldown
module arrow_pool_ctrl import arrow_pkg::*; #(
    parameter int NUM_ARROWS  = 4,
    parameter int ARROW_SPEED = DEF_ARROW_SPEED,
    parameter int COOLDOWN    = 8
) (
    input logic          sim_clk,
    input logic          reset,
    arrow_pool_ctrl_if.slave bus
);
    localparam int IW = (NUM_ARROWS > 1) ? $clog2(NUM_ARROWS) : 1;
    localparam logic [IW-1:0] LAST = IW'(NUM_ARROWS - 1);
    localparam logic [POS_W-1:0] SPD = POS_W'(ARROW_SPEED);

    logic [1:0]            state;
    logic [IW-1:0]         idx;
    logic [NUM_ARROWS-1:0] valid;
    logic [POS_W-1:0]      ax [NUM_ARROWS];
    logic [POS_W-1:0]      ay [NUM_ARROWS];
    logic                  fire_q, fire_pending, rise;
    logic                  blk_def, liz_def;
    logic                  blk_raw, liz_raw, hit_b, hit_l;
    logic                  any_free, cd_zero, spawn;
    logic [IW-1:0]         free_idx;
    logic [POS_W-1:0]      sx, sy;

    assign rise = bus.fire_button & ~fire_q;
    assign sx = ax[idx];
    assign sy = ay[idx];

    aabb_hit u_block (
        .px(sx), .py(sy),
        .bx(bus.block_x), .by(bus.block_y), .bw(bus.block_w), .bh(bus.block_h),
        .hit(blk_raw)
    );

    aabb_hit u_lizard (
        .px(sx), .py(sy),
        .bx(bus.lizard_x), .by(bus.lizard_y), .bw(bus.lizard_w), .bh(bus.lizard_h),
        .hit(liz_raw)
    );

    assign hit_b = (state == ST_CHECK) & valid[idx] & ~blk_def & blk_raw;
    assign hit_l = (state == ST_CHECK) & valid[idx] & ~liz_def & liz_raw;

    // lowest-index free slot, searched from the top so the smallest index wins
    always_comb begin
        free_idx = '0;
        any_free = 1'b0;
        for (int k = NUM_ARROWS - 1; k >= 0; k--) begin
            if (!valid[k]) begin
                free_idx = IW'(k);
                any_free = 1'b1;
            end
        end
    end

`ifdef ARROW_COOLDOWN_EN
    localparam int CW = $clog2(COOLDOWN + 2);
    logic [CW-1:0] cd;

    // reload on spawn, count down once per accepted frame tick, hold at zero
    always_ff @(posedge sim_clk or posedge reset) begin
        if (reset) cd <= '0;
        else if (state == ST_SPAWN && spawn) cd <= CW'(COOLDOWN);
        else if (state == ST_IDLE && bus.frame_tick && cd != '0) cd <= cd - 1'b1;
    end

    assign cd_zero = (cd == '0);
`else
    assign cd_zero = 1'b1;
`endif

    assign spawn = fire_pending & any_free & cd_zero;

    // frame sequencer: ticks are only accepted in IDLE, CHECK walks every slot once
    always_ff @(posedge sim_clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            idx   <= '0;
        end else begin
            state <= (state == ST_IDLE)  ? (bus.frame_tick ? ST_MOVE : ST_IDLE) :
                     (state == ST_MOVE)  ? ST_CHECK :
                     (state == ST_CHECK) ? ((idx == LAST) ? ST_SPAWN : ST_CHECK) : ST_IDLE;
            idx   <= (state == ST_CHECK) ? idx + 1'b1 : '0;
        end
    end

    // fire edge capture; a request survives until a spawn consumes it
    always_ff @(posedge sim_clk or posedge reset) begin
        if (reset) begin
            fire_q       <= 1'b0;
            fire_pending <= 1'b0;
        end else begin
            fire_q       <= bus.fire_button;
            fire_pending <= (fire_pending & ~(state == ST_SPAWN && spawn)) | rise;
        end
    end

    // sticky defeat flags, cleared only by reset
    always_ff @(posedge sim_clk or posedge reset) begin
        if (reset) begin
            blk_def <= 1'b0;
            liz_def <= 1'b0;
        end else begin
            blk_def <= blk_def | hit_b;
            liz_def <= liz_def | hit_l;
        end
    end

    // slot storage: move all, free on hit at the scan index, fill on spawn
    always_ff @(posedge sim_clk or posedge reset) begin
        if (reset) begin
            valid <= '0;
            for (int k = 0; k < NUM_ARROWS; k++) begin
                ax[k] <= '0;
                ay[k] <= '0;
            end
        end else begin
            if (state == ST_MOVE) begin
                for (int k = 0; k < NUM_ARROWS; k++) begin
                    if (valid[k]) begin
                        if (ay[k] < SPD) valid[k] <= 1'b0;
                        else ay[k] <= ay[k] - SPD;
                    end
                end
            end
            if (hit_b | hit_l) valid[idx] <= 1'b0;
            if (state == ST_SPAWN && spawn) begin
                valid[free_idx] <= 1'b1;
                ax[free_idx]    <= bus.playerPos[X_LSB +: POS_W];
                ay[free_idx]    <= bus.playerPos[Y_LSB +: POS_W];
            end
        end
    end

    for (genvar i = 0; i < NUM_ARROWS; i++) begin : g_pos
        assign bus.arrow_pos[SLOT_W*i +: SLOT_W] = {ax[i], ay[i]};
    end

    assign bus.arrow_valid     = valid;
    assign bus.block_defeated  = blk_def;
    assign bus.lizard_defeated = liz_def;
    assign bus.fire_ack        = (state == ST_SPAWN) & spawn;
    assign bus.busy            = (state != ST_IDLE);
endmodule

// File: doc/arrow_pool_ctrl.md
# arrow_pool_ctrl

Projectile scheduler for the player weapon. Owns a pool of NUM_ARROWS arrow slots and sequences each frame: movement, then collision scan, then spawn. Arbitrates fire requests against slot availability and a cooldown. Scans collisions one slot per cycle, so a single pair of hit comparators is shared across the whole pool. Sits between player input/position logic and the renderer/enemy-state logic.

## Interface
- NUM_ARROWS, 4: slot count (2..8).
- ARROW_SPEED, 5: pixels subtracted from y per frame.
- COOLDOWN, 8: frame ticks between spawns (used only with the cooldown feature).
- sim_clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- frame_tick  in  1  one-cycle pulse; starts a frame update.
- fire_button  in  1  raw level; rising edge is a fire request.
- playerPos  in  20  {x[19:10], y[9:0]}.
- block_x, block_y, block_w, block_h  in  10 each  destroyable block box.
- lizard_x, lizard_y, lizard_w, lizard_h  in  10 each  lizard box.
- arrow_valid  out  NUM_ARROWS  per-slot active flag.
- arrow_pos  out  20*NUM_ARROWS  slot i at [20i+19:20i], {x,y}.
- block_defeated, lizard_defeated  out  1  sticky hit flags.
- fire_ack  out  1  one-cycle pulse when an arrow spawns.
- busy  out  1  high when the FSM is not in IDLE.

## Operation
- FSM states: IDLE, MOVE, CHECK, SPAWN.
  - IDLE → MOVE on frame_tick.
  - MOVE → CHECK after 1 cycle.
  - CHECK stays NUM_ARROWS cycles, with scan index 0..NUM_ARROWS-1.
  - CHECK → SPAWN → IDLE.
- Fire request capture:
  - fire_button is registered every cycle in every state.
  - A rising edge sets fire_pending.
  - fire_pending stays set until serviced; further edges while pending are merged.
- MOVE: every valid slot does one of two things in the same cycle.
  - If y < ARROW_SPEED, the slot is freed (valid←0). No wrap-around.
  - Otherwise y ← y − ARROW_SPEED.
- CHECK, slot at scan index:
  - The slot is tested only if valid.
  - Box tests are inclusive: x ∈ [bx, bx+bw] and y ∈ [by, by+bh].
  - Sums are computed at 11 bits, so a box edge above 1023 does not wrap.
  - A target whose defeated flag is already set is skipped; arrows pass through it.
  - On a hit, the target's defeated flag is set and the slot is freed.
  - One arrow hitting both targets in the same cycle sets both flags and frees the slot.
- SPAWN:
  - Condition: fire_pending, a free slot exists, and cooldown == 0.
  - The lowest-index free slot is filled with playerPos as sampled in this cycle.
  - On spawn: fire_pending←0, fire_ack=1, cooldown←COOLDOWN.
  - If the condition fails, fire_pending is kept for the next frame.
- Cooldown counter:
  - Decrements once per accepted frame_tick.
  - Saturates at 0.
- Defeated flags are cleared only by reset.

## Timing
- Reset: all outputs 0, arrow_pos all-zero, state IDLE, fire_pending 0, cooldown 0.
- Reset mid-frame aborts immediately.
- Frame sequence: frame_tick sampled in IDLE at cycle t.
  - MOVE at t+1.
  - CHECK at t+2 .. t+1+NUM_ARROWS.
  - SPAWN at t+2+NUM_ARROWS.
  - IDLE at t+3+NUM_ARROWS.
- A frame_tick arriving while busy is dropped; it does not decrement the cooldown.
- Defeated flags and valid bits update at the clock edge ending the relevant cycle.
- A newly spawned arrow first moves on the next frame.
- fire_ack is high for exactly the SPAWN cycle.

## Configuration
- ARROW_COOLDOWN_EN defined:
  - The cooldown counter is built in.
  - Consecutive spawns are at least COOLDOWN accepted frame ticks apart.
- ARROW_COOLDOWN_EN undefined:
  - No counter is built; the condition is treated as cooldown == 0.
  - A pending request spawns at the next SPAWN that has a free slot.

## Structure
- Package arrow_pkg:
  - State encoding for IDLE/MOVE/CHECK/SPAWN.
  - POS_W=10 and the {x,y} packing offsets.
  - Default ARROW_SPEED.
- Sub-module aabb_hit: combinational inclusive point-in-box test with 11-bit sums.
  - Instantiated twice (block, lizard).
  - Both instances are fed the slot selected by the scan-index mux.

## Test plan
- Spawn and move (reset, fire edge, playerPos={100,200}, frame_tick): fire_ack pulse at SPAWN, arrow_valid=4'b0001, slot0={100,200}. Next tick: slot0 y=195.
- Off-screen: slot0 y=3 at frame_tick → valid 0 after MOVE, no underflow to 1022.
- Block hit: block {95,150,10,10}, arrow spawned at {100,200}. After the 8th move y=160 → block_defeated=1 at that CHECK, slot0 freed, lizard_defeated stays 0.
- Cooldown (ARROW_COOLDOWN_EN, COOLDOWN=8): two fire edges one frame apart → second spawn exactly 8 accepted ticks after the first. Without the macro → second spawn on the next frame.
- Pool full: 4 arrows active, fire edge → no spawn, fire_pending held. Free slot 2 by off-screen → spawn lands in slot 2 that frame.
- Async reset during CHECK with active arrows → all outputs 0 immediately, busy 0, no fire_ack.
